// File: rtl/div32p2_pipe_if.sv
// Operand/result bundle for the pipelined 64/32 unsigned divider.
// The master drives the dividend and divisor; the slave (the divider)
// returns the registered quotient and remainder.
interface div32p2_pipe_if;
    logic [63:0] x;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;

    modport master (output x, output d, input q, input r);
    modport slave  (input x, input d, output q, output r);
endinterface

// File: rtl/div32p2_pipe.sv
// Two-stage pipelined unsigned divider: 64-bit dividend / 32-bit divisor.
// Each stage performs 16 restoring-division steps. The overflow and
// divide-by-zero case (x[63:32] >= d) is detected in stage 1. Stage 2 then
// returns q = all ones and r = x[31:0] for that case.
module div32p2_pipe (
    div32p2_pipe_if.slave bus,
    input  logic          clk,
    input  logic          rstn
);

    // Sixteen restoring steps. Returns {partial remainder, 16 quotient bits}.
    // The incoming remainder is below the divisor in the normal case, so the
    // 33-bit trial value never loses a bit.
    function automatic logic [47:0] div_steps(input logic [31:0] rem_in,
                                              input logic [15:0] bits,
                                              input logic [31:0] div);
        logic [32:0] t;
        logic [31:0] rem;
        logic [15:0] qb;
        rem = rem_in;
        qb  = '0;
        for (int i = 15; i >= 0; i--) begin
            t = {rem, bits[i]};
            if (t >= {1'b0, div}) begin
                t     = t - {1'b0, div};
                qb[i] = 1'b1;
            end
            rem = t[31:0];
        end
        return {rem, qb};
    endfunction

    logic [31:0] s1_rem;
    logic [15:0] s1_qhi;
    logic [31:0] s1_d;
    logic [31:0] s1_xlo;
    logic        s1_ovf;
    logic        s1_live;

    logic [47:0] s1_next;
    logic [47:0] s2_next;

    assign s1_next = div_steps(bus.x[63:32], bus.x[31:16], bus.d);
    assign s2_next = div_steps(s1_rem, s1_xlo[15:0], s1_d);

    // Stage 1 registers: upper quotient half, partial remainder, divisor, low dividend.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_rem  <= '0;
            s1_qhi  <= '0;
            s1_d    <= '0;
            s1_xlo  <= '0;
            s1_ovf  <= 1'b0;
            s1_live <= 1'b0;
        end else begin
            s1_rem  <= s1_next[47:16];
            s1_qhi  <= s1_next[15:0];
            s1_d    <= bus.d;
            s1_xlo  <= bus.x[31:0];
            s1_ovf  <= (bus.x[63:32] >= bus.d);
            s1_live <= 1'b1;
        end
    end

    // Stage 2 registers the final result. A cleared stage 1 (just out of
    // reset) yields zeros rather than dividing its zero contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.q <= '0;
            bus.r <= '0;
        end else if (!s1_live) begin
            bus.q <= '0;
            bus.r <= '0;
        end else if (s1_ovf) begin
            bus.q <= 32'hFFFF_FFFF;
            bus.r <= s1_xlo;
        end else begin
            bus.q <= {s1_qhi, s2_next[15:0]};
            bus.r <= s2_next[47:16];
        end
    end

endmodule

// File: tb/tb_div32p2_pipe.sv
// Self-checking bench for div32p2_pipe: directed cases plus a randomized
// one-op-per-clock sweep against a plain-arithmetic reference model.
module tb_div32p2_pipe;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } result_t;

    logic clk;
    logic rstn;
    int   num_checks;
    int   num_fails;

    result_t pending[$];

    div32p2_pipe_if bus ();

    div32p2_pipe dut (
        .bus  (bus.slave),
        .clk  (clk),
        .rstn (rstn)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference division straight from the arithmetic definition.
    function automatic result_t ref_div(input logic [63:0] xv, input logic [31:0] dv);
        result_t res;
        logic [63:0] d64;
        logic [63:0] quo;
        logic [63:0] rem;
        d64 = {32'b0, dv};
        if (xv[63:32] >= dv) begin
            res.q = 32'hFFFF_FFFF;
            res.r = xv[31:0];
        end else begin
            quo   = xv / d64;
            rem   = xv % d64;
            res.q = quo[31:0];
            res.r = rem[31:0];
        end
        return res;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus. On the falling edge, the result from two edges
    // back is checked, then new operands and reset are driven. The expected
    // result for the upcoming edge is queued. A reset edge leaves zeros for
    // two cycles: the cleared output, then the cleared stage-1 contents.
    task automatic applyStimulus(input string tag, input logic [63:0] xv,
                                 input logic [31:0] dv, input logic rv);
        result_t e;
        result_t z;
        @(negedge clk);
        if (pending.size() == 2) begin
            e = pending.pop_front();
            checkOutput({tag, ".q"}, bus.q, e.q);
            checkOutput({tag, ".r"}, bus.r, e.r);
        end
        bus.x = xv;
        bus.d = dv;
        rstn  = rv;
        if (!rv) begin
            z.q = '0;
            z.r = '0;
            pending.delete();
            pending.push_back(z);
            pending.push_back(z);
        end else begin
            pending.push_back(ref_div(xv, dv));
        end
    endtask

    initial begin
        logic [31:0] dv;
        logic [31:0] xhi;
        logic [31:0] xlo;
        num_checks = 0;
        num_fails  = 0;
        rstn  = 1'b0;
        bus.x = '0;
        bus.d = '0;

        applyStimulus("reset", 64'd0, 32'd0, 1'b0);
        applyStimulus("reset", 64'd0, 32'd0, 1'b0);
        applyStimulus("reset", 64'd100, 32'd7, 1'b1);
        applyStimulus("b2b", 64'h0000_0001_0000_0000, 32'd2, 1'b1);
        applyStimulus("b2b", 64'd1000, 32'd10, 1'b1);
        applyStimulus("dbz", 64'h0000_0000_DEAD_BEEF, 32'd0, 1'b1);
        applyStimulus("maxq", 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("ovf", 64'h0000_0005_0000_0000, 32'd5, 1'b1);
        applyStimulus("ovf2", 64'hFFFF_FFFF_1234_5678, 32'h8000_0000, 1'b1);
        applyStimulus("one", 64'h0000_0000_ABCD_0123, 32'd1, 1'b1);

        for (int i = 0; i < 100; i++) begin
            applyStimulus("dbz_rand", {32'b0, $urandom()}, 32'd0, 1'b1);
        end

        // A reset with operations in flight must discard them.
        applyStimulus("midrst", 64'd77, 32'd3, 1'b1);
        applyStimulus("midrst", 64'd99, 32'd4, 1'b1);
        applyStimulus("midrst", 64'd55, 32'd6, 1'b0);
        applyStimulus("midrst", 64'd500, 32'd9, 1'b1);

        for (int i = 0; i < 30000; i++) begin
            dv  = $urandom() >> ((i % 24) + 1);
            xhi = (dv == 0) ? 32'd0 : ($urandom() % dv);
            xlo = $urandom();
            applyStimulus("sweep", {xhi, xlo}, dv, 1'b1);
        end

        applyStimulus("drain", 64'd0, 32'd1, 1'b1);
        applyStimulus("drain", 64'd0, 32'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
